// File: rtl/wb_stream_dma_wr_pkg.sv
// Shared types for the stream-to-Wishbone write engine.
// Holds the control FSM state encoding used by wb_stream_dma_wr.
package wb_stream_dma_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_WRITE     = 2'd2
    } state_e;

endpackage

// File: rtl/wb_stream_dma_wr.sv
// Stream-to-Wishbone write engine: takes a (byte address, word count)
// command, then moves that many stream words to consecutive word
// addresses through a Wishbone classic master port.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_addr/len        start byte address and word count
//   cmd_valid/ready     command handshake
//   s_data/valid/ready  input data stream
//   wb_*                Wishbone classic master (write only)
//   busy                transfer in progress
//   done                one-cycle pulse at transfer end
//   err                 one-cycle pulse when aborted by wb_err_i
module wb_stream_dma_wr
    import wb_stream_dma_wr_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_we_o,
    output logic [SELECT_WIDTH-1:0] wb_sel_o,
    output logic                    wb_stb_o,
    output logic                    wb_cyc_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    // Word alignment mask and per-word address step.
    localparam logic [ADDR_WIDTH-1:0] ADR_MASK =
        ~(ADDR_WIDTH'(SELECT_WIDTH - 1));
    localparam logic [ADDR_WIDTH-1:0] ADR_STEP =
        ADDR_WIDTH'(SELECT_WIDTH);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    cyc_q, cyc_d;
    logic                    we_q, we_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    s_ready_q, s_ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        len_d       = len_q;
        dat_d       = dat_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        cmd_ready_d = cmd_ready_q;
        s_ready_d   = s_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // cmd_ready is 0 straight out of reset and rises here.
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    adr_d = cmd_addr & ADR_MASK;
                    len_d = cmd_len;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cmd_ready_d = 1'b0;
                        s_ready_d   = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = ST_WAIT_DATA;
                    end
                end
            end

            ST_WAIT_DATA: begin
                if (s_valid && s_ready_q) begin
                    dat_d     = s_data;
                    cyc_d     = 1'b1;
                    we_d      = 1'b1;
                    sel_d     = '1;
                    s_ready_d = 1'b0;
                    state_d   = ST_WRITE;
                end
            end

            ST_WRITE: begin
                // Error wins over a simultaneous ack: abort the transfer.
                if (wb_err_i) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = '0;
                    err_d       = 1'b1;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (wb_ack_i) begin
                    // stb drops right after the ack so a registered-ack
                    // slave never sees a second request for this word.
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    sel_d = '0;
                    adr_d = adr_q + ADR_STEP;
                    len_d = len_q - LEN_WIDTH'(1);
                    if (len_q == LEN_WIDTH'(1)) begin
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        cmd_ready_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        s_ready_d = 1'b1;
                        state_d   = ST_WAIT_DATA;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            len_q       <= '0;
            dat_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            cmd_ready_q <= 1'b0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            len_q       <= len_d;
            dat_q       <= dat_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            cmd_ready_q <= cmd_ready_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign s_ready   = s_ready_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    // Single-beat classic cycles: strobe and cycle are the same flop.
    assign wb_stb_o  = cyc_q;
    assign wb_cyc_o  = cyc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_wb_stream_dma_wr.sv
// Randomized scoreboard bench for wb_stream_dma_wr.
// Includes a Wishbone slave model with programmable ack delay and error.
module tb_wb_stream_dma_wr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    wb_stream_dma_wr #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16),
        .SELECT_WIDTH(4),
        .LEN_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o),
        .wb_stb_o(wb_stb_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] stim_q[$];
    logic [31:0] mem [int];

    int n_tests = 0;
    int n_fail = 0;
    int ack_delay = 0;
    int err_at = -1;
    int wr_total = 0;
    int ok_total = 0;
    int cyc_seen = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wishbone slave: ack (and optionally err) after ack_delay extra cycles.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
                if (wait_cnt >= ack_delay) begin
                    wb_ack_i <= 1'b1;
                    wb_err_i <= (wr_total == err_at);
                end
                wait_cnt = wait_cnt + 1;
            end else begin
                wb_ack_i <= 1'b0;
                wb_err_i <= 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every completed bus cycle.
    initial begin
        logic        stb_prev;
        logic        ack_prev;
        logic [15:0] adr_prev;
        logic [31:0] dat_prev;
        wr_t         e;
        stb_prev = 1'b0;
        ack_prev = 1'b0;
        adr_prev = '0;
        dat_prev = '0;
        forever begin
            @(negedge clk);
            if (wb_stb_o && stb_prev && !ack_prev) begin
                chk("hold_adr", 64'(wb_adr_o), 64'(adr_prev));
                chk("hold_dat", 64'(wb_dat_o), 64'(dat_prev));
            end
            if (wb_cyc_o) cyc_seen++;
            if (done) begin
                done_cnt++;
                chk("busy_falls_with_done", 64'(busy), 64'd0);
            end
            if (err) err_cnt++;
            if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_adr", 64'(wb_adr_o), 64'(e.a));
                    chk("wr_dat", 64'(wb_dat_o), 64'(e.d));
                    chk("wr_sel", 64'(wb_sel_o), 64'hF);
                    chk("wr_we", 64'(wb_we_o), 64'd1);
                end
                if (!wb_err_i) begin
                    mem[int'(wb_adr_o)] = wb_dat_o;
                    ok_total++;
                end
                wr_total++;
            end
            stb_prev = wb_stb_o;
            ack_prev = wb_ack_i | wb_err_i;
            adr_prev = wb_adr_o;
            dat_prev = wb_dat_o;
        end
    end

    // One command. err_word >= 0: slave errors on that word.
    // rst_word >= 0: reset is pulsed while that word is on the bus.
    task automatic run_cmd(input logic [15:0] addr, input int len,
                           input int err_word, input int delay,
                           input int vpct, input int rst_word);
        logic [31:0] w[$];
        int n_exp, hs, idx, t;
        int cyc0, done0, err0, ok0, base;
        bit got_done;

        w = stim_q;
        stim_q.delete();
        while (w.size() < len) w.push_back($urandom);
        n_exp = (err_word >= 0) ? err_word + 1 : len;
        for (int i = 0; i < n_exp; i++) begin
            wr_t e;
            e.a = 16'(((int'(addr) / 4) * 4 + 4 * i) % 65536);
            e.d = w[i];
            exp_q.push_back(e);
        end
        ack_delay = delay;
        err_at = (err_word >= 0) ? wr_total + err_word : -1;
        base = wr_total;
        cyc0 = cyc_seen;
        done0 = done_cnt;
        err0 = err_cnt;
        ok0 = ok_total;

        @(negedge clk);
        cmd_addr = addr;
        cmd_len = 16'(len);
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("cmd_accept_timeout", 64'd1, 64'd0);
        @(negedge clk);
        cmd_valid = 1'b0;

        if (len == 0) begin
            chk("zero_done", 64'(done), 64'd1);
            chk("zero_busy", 64'(busy), 64'd0);
            chk("zero_s_ready", 64'(s_ready), 64'd0);
            @(negedge clk);
            chk("zero_done_width", 64'(done), 64'd0);
            repeat (3) begin
                @(negedge clk);
                chk("zero_s_ready_low", 64'(s_ready), 64'd0);
            end
            chk("zero_no_cyc", 64'(cyc_seen - cyc0), 64'd0);
            chk("zero_done_cnt", 64'(done_cnt - done0), 64'd1);
            return;
        end

        chk("busy_after_cmd", 64'(busy), 64'd1);
        chk("s_ready_after_cmd", 64'(s_ready), 64'd1);
        idx = 0;
        hs = 0;
        t = 0;
        got_done = 1'b0;
        while (t < 3000) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (rst_word >= 0 && wr_total - base == rst_word &&
                wb_stb_o && !wb_ack_i && !wb_err_i) begin
                break;
            end
            s_valid = (idx < len) && ($urandom_range(99) < vpct);
            if (idx < len) s_data = w[idx];
            if (s_valid && s_ready) begin
                idx++;
                hs++;
            end
            @(negedge clk);
            t++;
        end
        last_cycles = t;

        if (rst_word >= 0) begin
            s_valid = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            chk("rst_outputs_zero",
                {4'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
                 wb_dat_o, cmd_ready, s_ready, busy, done, err}, 64'd0);
            rst = 1'b0;
            chk("rst_leftover", 64'(exp_q.size()), 64'(len - rst_word));
            exp_q.delete();
            @(negedge clk);
            chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
            @(negedge clk);
            chk("rst_no_done", 64'(done_cnt - done0), 64'd0);
            chk("rst_no_err", 64'(err_cnt - err0), 64'd0);
            chk("rst_written", 64'(ok_total - ok0), 64'(rst_word));
            return;
        end

        if (!got_done) chk("xfer_timeout", 64'd1, 64'd0);
        chk("end_err", 64'(err), 64'(err_word >= 0));
        chk("end_busy", 64'(busy), 64'd0);
        chk("stream_handshakes", 64'(hs), 64'(n_exp));
        if (err_word >= 0 && idx < len) begin
            s_valid = 1'b1;
            s_data = w[idx];
        end else begin
            s_valid = 1'b0;
        end
        @(negedge clk);
        chk("after_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("after_done_low", 64'({done, err}), 64'd0);
        repeat (2) begin
            chk("after_s_ready_low", 64'(s_ready), 64'd0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("written", 64'(ok_total - ok0),
            64'((err_word >= 0) ? err_word : len));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("done_cnt", 64'(done_cnt - done0), 64'd1);
        chk("err_cnt", 64'(err_cnt - err0), 64'((err_word >= 0) ? 1 : 0));
    endtask

    initial begin
        int len, ew;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero",
            {4'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
             wb_dat_o, cmd_ready, s_ready, busy, done, err}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_s_ready", 64'(s_ready), 64'd0);

        stim_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_cmd(16'h0100, 4, -1, 0, 100, -1);
        chk("rate_3_per_word", 64'(last_cycles), 64'd12);
        for (int i = 0; i < 4; i++) begin
            chk("mem_readback", 64'(mem[32'h100 + 4 * i]),
                64'(32'h11111111 * (i + 1)));
        end

        run_cmd(16'h0200, 0, -1, 0, 100, -1);
        run_cmd(16'h0103, 1, -1, 0, 100, -1);
        run_cmd(16'hFFF8, 4, -1, 1, 100, -1);
        run_cmd(16'h2000, 8, -1, 5, 50, -1);
        run_cmd(16'h3000, 4, 1, 0, 100, -1);
        run_cmd(16'h4000, 4, -1, 2, 100, 2);
        run_cmd(16'h4000, 3, -1, 0, 100, -1);

        for (int n = 0; n < 25; n++) begin
            len = $urandom_range(6);
            ew = -1;
            if (len > 0 && $urandom_range(4) == 0) ew = $urandom_range(len - 1);
            run_cmd(16'($urandom), len, ew, $urandom_range(5),
                    $urandom_range(100, 30), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
